// File: rtl/en_strobe_gen_pkg.sv
// en_strobe_gen_pkg: shared mode encodings and FSM state type for the enable strobe generator
package en_strobe_gen_pkg;
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_BURST = 1'b1;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/en_strobe_gen_div_cnt.sv
// strobe_div_cnt: loadable W-bit phase down-counter (clk, reset_n, load/load_val, dec) with zero flag
module strobe_div_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] phase_q, phase_d;
  always_comb phase_d = load ? load_val : dec ? phase_q - 1'b1 : phase_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) phase_q <= '0;
    else phase_q <= phase_d;
  assign zero = phase_q == '0;
endmodule

// File: rtl/en_strobe_gen.sv
// en_strobe_gen: programmable-period enable strobe (en_out) with continuous/burst modes, start/stop in, busy/done/strobe_cnt status out
module en_strobe_gen
  import en_strobe_gen_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] strobe_cnt
);
  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             load, dec, zero;
  logic [DIV_W-1:0] load_val;
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    div_d    = div_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = div_q;
    if (state_q == IDLE) begin
      if (start && !stop) begin
        if (mode == MODE_BURST && burst_len == '0) done_d = 1'b1;
        else begin
          mode_d   = mode;
          div_d    = div;
          len_d    = burst_len;
          cnt_d    = '0;
          load     = 1'b1;
          load_val = div;
          state_d  = RUN;
        end
      end
    end else if (stop) state_d = IDLE;
    else if (zero) begin
      en_d  = 1'b1;
      load  = 1'b1;
      cnt_d = cnt_inc;
      if (mode_q == MODE_BURST && cnt_inc == len_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end else dec = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_CONT;
      div_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  strobe_div_cnt #(.W(DIV_W)) u_div (
    .clk(clk), .reset_n(reset_n), .load(load), .dec(dec), .load_val(load_val), .zero(zero)
  );
  assign en_out     = en_q;
  assign busy       = state_q == RUN;
  assign done       = done_q;
  assign strobe_cnt = cnt_q;
endmodule

// File: tb/tb_en_strobe_gen.sv
// tb_en_strobe_gen: table-driven, directed and randomized checks of en_strobe_gen against a cycle-count reference model
module tb_en_strobe_gen;
  logic        clk = 0, reset_n = 0, start = 0, stop = 0, mode = 0;
  logic [15:0] div = 0;
  logic [7:0]  burst_len = 0;
  logic        en_out, busy, done;
  logic [7:0]  strobe_cnt;
  int checks = 0, errors = 0;
  en_strobe_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode), .div(div),
    .burst_len(burst_len), .en_out(en_out), .busy(busy), .done(done), .strobe_cnt(strobe_cnt)
  );
  always #5 clk = ~clk;
  logic       x_en, x_busy, x_done;
  logic [7:0] x_cnt;
  bit         m_run, m_mode;
  int         m_t, m_div, m_len;
  typedef struct {
    logic st, sp, md; logic [15:0] dv; logic [7:0] ln;
    logic en, bz, dn; logic [7:0] cn;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, " en_out"}, en_out, x_en);
    chk({tag, " busy"}, busy, x_busy);
    chk({tag, " done"}, done, x_done);
    chk({tag, " strobe_cnt"}, strobe_cnt, x_cnt);
  endtask
  task automatic model_reset();
    {x_en, x_busy, x_done, x_cnt} = '0;
    m_run = 0; m_t = 0;
  endtask
  // Strobes fall on every (div+1)-th edge after the accepting edge.
  task automatic model_edge();
    x_en = 0; x_done = 0;
    if (!m_run) begin
      if (start && !stop) begin
        if (mode && burst_len == 0) x_done = 1;
        else begin
          m_run = 1; m_t = 0; m_mode = mode; m_div = int'(div); m_len = int'(burst_len);
          x_cnt = 0; x_busy = 1;
        end
      end
    end else if (stop) begin
      m_run = 0; x_busy = 0;
    end else begin
      m_t++;
      if (m_t % (m_div + 1) == 0) begin
        x_en = 1; x_cnt = x_cnt + 1;
        if (m_mode && m_t / (m_div + 1) == m_len) begin
          x_done = 1; x_busy = 0; m_run = 0;
        end
      end
    end
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1 chk_all(tag);
  endtask
  task automatic do_reset(input string tag);
    reset_n = 0;
    model_reset();
    #2 chk_all(tag);
    @(negedge clk);
    reset_n = 1;
  endtask
  task automatic drive(input logic st, input logic sp, input logic md, input logic [15:0] dv, input logic [7:0] ln);
    start = st; stop = sp; mode = md; div = dv; burst_len = ln;
  endtask
  int strobes;
  initial begin
    vecs[0]  = '{1, 0, 1, 16'd0, 8'd5, 0, 1, 0, 8'd0};
    vecs[1]  = '{0, 0, 0, 16'd7, 8'd9, 1, 1, 0, 8'd1};
    vecs[2]  = '{0, 0, 0, 16'd7, 8'd9, 1, 1, 0, 8'd2};
    vecs[3]  = '{1, 0, 0, 16'd7, 8'd9, 1, 1, 0, 8'd3};
    vecs[4]  = '{0, 0, 0, 16'd7, 8'd9, 1, 1, 0, 8'd4};
    vecs[5]  = '{0, 0, 0, 16'd7, 8'd9, 1, 0, 1, 8'd5};
    vecs[6]  = '{0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 8'd5};
    vecs[7]  = '{1, 0, 1, 16'd3, 8'd0, 0, 0, 1, 8'd5};
    vecs[8]  = '{0, 0, 1, 16'd3, 8'd0, 0, 0, 0, 8'd5};
    vecs[9]  = '{1, 1, 0, 16'd0, 8'd4, 0, 0, 0, 8'd5};
    vecs[10] = '{0, 0, 0, 16'd0, 8'd4, 0, 0, 0, 8'd5};
    repeat (2) @(negedge clk);
    do_reset("reset");
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].md, vecs[i].dv, vecs[i].ln);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d en_out", i), en_out, vecs[i].en);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].bz);
      chk($sformatf("vec%0d done", i), done, vecs[i].dn);
      chk($sformatf("vec%0d strobe_cnt", i), strobe_cnt, vecs[i].cn);
    end
    do_reset("reset2");
    drive(1, 0, 0, 16'd3, 8'd0);
    step("cont start");
    drive(0, 0, 0, 16'd3, 8'd0);
    strobes = 0;
    for (int i = 1; i <= 9; i++) begin
      step("cont run");
      if (en_out) strobes++;
    end
    drive(0, 1, 0, 16'd3, 8'd0);
    step("cont stop");
    drive(0, 0, 0, 16'd3, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step("cont after stop");
      if (en_out) strobes++;
    end
    chk("cont strobe total", strobes, 2);
    drive(1, 0, 0, 16'd2, 8'd0);
    step("restart start");
    strobes = 0;
    for (int i = 1; i <= 12; i++) begin
      drive(i == 4, 0, 0, (i >= 2) ? 16'd9 : 16'd2, 8'd0);
      step("restart ignored");
      if (en_out) strobes++;
    end
    chk("period kept strobes", strobes, 4);
    drive(0, 1, 0, 16'd2, 8'd0);
    step("restart stop");
    drive(1, 0, 0, 16'd2, 8'd0);
    step("zstop start");
    drive(0, 0, 0, 16'd2, 8'd0);
    step("zstop p1");
    step("zstop p2");
    drive(0, 1, 0, 16'd2, 8'd0);
    step("zstop due");
    chk("zstop no strobe", en_out, 0);
    drive(0, 0, 0, 16'd2, 8'd0);
    step("zstop idle");
    drive(1, 0, 0, 16'd3, 8'd0);
    step("rst start");
    drive(0, 0, 0, 16'd3, 8'd0);
    repeat (5) step("rst run");
    do_reset("reset midrun");
    repeat (8) step("after reset");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rand reset");
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 4)), 8'($urandom_range(0, 6)));
      step("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
